// File: rtl/iq_entry_allocator_pkg.sv
// Shared constants and age-compare helper for the issue-queue entry allocator.
// The ROB and LSQ flush logic reuse isyounger() so every block agrees on what
// "younger than the mispredicted branch" means.
// No ports (package).
package iq_entry_allocator_pkg;

  localparam int unsigned ENT_NUM = 16;  // number of IQ entries
  localparam int unsigned ENT_SEL = 4;   // log2(ENT_NUM)
  localparam int unsigned ROB_SEL = 6;   // ROB index width

  // A tag is younger when it sits after the reference in ROB order. The sorting
  // bit flips on every ROB wrap, so when the bits differ the order of the raw
  // indices is inverted.
  function automatic logic isyounger(input logic [ROB_SEL-1:0] rob,
                                     input logic               sb,
                                     input logic [ROB_SEL-1:0] prob,
                                     input logic               psb);
    return ((sb == psb) && (rob > prob)) || ((sb != psb) && (rob < prob));
  endfunction

  function automatic logic [ENT_SEL:0] popcount(input logic [ENT_NUM-1:0] vec);
    logic [ENT_SEL:0] cnt;
    cnt = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      cnt = cnt + {{ENT_SEL{1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/iq_entry_allocator_first_two_set.sv
// first_two_set priority encoder: returns the indices of the lowest and the
// second-lowest set bits of vec, each with a valid flag.
// Ports:
//   vec     in   Width  input bit vector
//   idx1    out  SelW   index of lowest set bit (0 when valid1 = 0)
//   idx2    out  SelW   index of next set bit above idx1 (0 when valid2 = 0)
//   valid1  out  1      at least one bit set
//   valid2  out  1      at least two bits set
module iq_entry_allocator_first_two_set #(
  parameter int unsigned Width = 16,
  parameter int unsigned SelW  = 4
) (
  input  logic [Width-1:0] vec,
  output logic [SelW-1:0]  idx1,
  output logic [SelW-1:0]  idx2,
  output logic             valid1,
  output logic             valid2
);

  always_comb begin
    idx1   = '0;
    idx2   = '0;
    valid1 = 1'b0;
    valid2 = 1'b0;
    for (int i = 0; i < Width; i++) begin
      if (vec[i]) begin
        if (!valid1) begin
          valid1 = 1'b1;
          idx1   = SelW'(i);
        end else if (!valid2) begin
          valid2 = 1'b1;
          idx2   = SelW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/iq_entry_allocator.sv
// Issue-queue entry allocator. Hands the two lowest free IQ entry indices to
// dispatch each cycle, reclaims entries as the select logic issues them, and on
// a branch mispredict bulk-frees every entry whose ROB tag is younger than the
// mispredicted branch.
//
// Optional build macro IQ_ALLOC_CHECK_EN: adds simulation-only protocol/state
// checks and exposes the free-entry counter on free_count. Functional
// behaviour is identical with or without it.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   invalid1/2                 dispatch slot carries no instruction
//   stall_DP                   dispatch stalled, no allocation
//   rob_num_1/2, rob_sorting_bit_1/2   ROB tag of each dispatch slot
//   issue_valid_1/2, issue_entry_1/2   entries released by select
//   prmiss, prmiss_rob_num, prmiss_rob_sorting_bit   mispredict recovery
//   iq_entry_num_1/2           lowest / second-lowest free entry
//   allocatable                at least two entries free
//   free_count                 (IQ_ALLOC_CHECK_EN only) free entry count
module iq_entry_allocator
  import iq_entry_allocator_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               invalid1,
  input  logic               invalid2,
  input  logic               stall_DP,
  input  logic [ROB_SEL-1:0] rob_num_1,
  input  logic [ROB_SEL-1:0] rob_num_2,
  input  logic               rob_sorting_bit_1,
  input  logic               rob_sorting_bit_2,
  input  logic               issue_valid_1,
  input  logic               issue_valid_2,
  input  logic [ENT_SEL-1:0] issue_entry_1,
  input  logic [ENT_SEL-1:0] issue_entry_2,
  input  logic               prmiss,
  input  logic [ROB_SEL-1:0] prmiss_rob_num,
  input  logic               prmiss_rob_sorting_bit,
  output logic [ENT_SEL-1:0] iq_entry_num_1,
  output logic [ENT_SEL-1:0] iq_entry_num_2,
  output logic               allocatable
`ifdef IQ_ALLOC_CHECK_EN
  ,
  output logic [ENT_SEL:0]   free_count
`endif
);

  logic [ENT_NUM-1:0] free_q, free_d;
  logic [ENT_SEL:0]   free_cnt_q, free_cnt_d;
  logic [ROB_SEL-1:0] tag_rob_q [ENT_NUM];
  logic               tag_sb_q  [ENT_NUM];

  logic               sel_valid1, sel_valid2;
  logic               alloc_ok, alloc1, alloc2;
  logic [ENT_NUM-1:0] alloc_mask, issue_mask, release_mask, flush_mask;

  iq_entry_allocator_first_two_set #(
    .Width(ENT_NUM),
    .SelW (ENT_SEL)
  ) u_first_two_set (
    .vec   (free_q),
    .idx1  (iq_entry_num_1),
    .idx2  (iq_entry_num_2),
    .valid1(sel_valid1),
    .valid2(sel_valid2)
  );

  assign allocatable = (free_cnt_q >= (ENT_SEL+1)'(2));

  // Mispredict recovery outranks allocation; an allocation while not
  // allocatable is a protocol error and is dropped.
  assign alloc_ok = !prmiss && !stall_DP && allocatable;
  assign alloc1   = alloc_ok && !invalid1 && sel_valid1;
  assign alloc2   = alloc_ok && !invalid2 && sel_valid2;

  always_comb begin
    alloc_mask = '0;
    if (alloc1) alloc_mask[iq_entry_num_1] = 1'b1;
    if (alloc2) alloc_mask[iq_entry_num_2] = 1'b1;

    issue_mask = '0;
    if (issue_valid_1) issue_mask[issue_entry_1] = 1'b1;
    if (issue_valid_2) issue_mask[issue_entry_2] = 1'b1;
    // Only real 0->1 transitions count; duplicate or stale issues drop out here.
    release_mask = issue_mask & ~free_q;

    flush_mask = '0;
    if (prmiss) begin
      for (int i = 0; i < ENT_NUM; i++) begin
        if (!free_q[i] && isyounger(tag_rob_q[i], tag_sb_q[i],
                                    prmiss_rob_num, prmiss_rob_sorting_bit)) begin
          flush_mask[i] = 1'b1;
        end
      end
    end

    free_d     = (free_q & ~alloc_mask) | release_mask | flush_mask;
    free_cnt_d = popcount(free_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      free_q     <= '1;
      free_cnt_q <= (ENT_SEL+1)'(ENT_NUM);
      for (int i = 0; i < ENT_NUM; i++) begin
        tag_rob_q[i] <= '0;
        tag_sb_q[i]  <= 1'b0;
      end
    end else begin
      free_q     <= free_d;
      free_cnt_q <= free_cnt_d;
      if (alloc1) begin
        tag_rob_q[iq_entry_num_1] <= rob_num_1;
        tag_sb_q[iq_entry_num_1]  <= rob_sorting_bit_1;
      end
      if (alloc2) begin
        tag_rob_q[iq_entry_num_2] <= rob_num_2;
        tag_sb_q[iq_entry_num_2]  <= rob_sorting_bit_2;
      end
    end
  end

`ifdef IQ_ALLOC_CHECK_EN
  assign free_count = free_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!prmiss && !stall_DP && !allocatable && (!invalid1 || !invalid2)) begin
        $error("iq_entry_allocator: allocation attempted while not allocatable");
      end
      if (issue_valid_1 && free_q[issue_entry_1]) begin
        $error("iq_entry_allocator: issue port 1 names free entry %0d", issue_entry_1);
      end
      if (issue_valid_2 && free_q[issue_entry_2]) begin
        $error("iq_entry_allocator: issue port 2 names free entry %0d", issue_entry_2);
      end
      if (free_cnt_q != popcount(free_q)) begin
        $error("iq_entry_allocator: free_cnt %0d disagrees with free vector", free_cnt_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_iq_entry_allocator.sv
// Directed self-checking bench for iq_entry_allocator (default build).
module tb_iq_entry_allocator;

  logic       clk = 1'b0;
  logic       reset;
  logic       invalid1, invalid2, stall_DP;
  logic [5:0] rob_num_1, rob_num_2;
  logic       rob_sorting_bit_1, rob_sorting_bit_2;
  logic       issue_valid_1, issue_valid_2;
  logic [3:0] issue_entry_1, issue_entry_2;
  logic       prmiss;
  logic [5:0] prmiss_rob_num;
  logic       prmiss_rob_sorting_bit;
  logic [3:0] iq_entry_num_1, iq_entry_num_2;
  logic       allocatable;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  iq_entry_allocator dut (
    .clk                   (clk),
    .reset                 (reset),
    .invalid1              (invalid1),
    .invalid2              (invalid2),
    .stall_DP              (stall_DP),
    .rob_num_1             (rob_num_1),
    .rob_num_2             (rob_num_2),
    .rob_sorting_bit_1     (rob_sorting_bit_1),
    .rob_sorting_bit_2     (rob_sorting_bit_2),
    .issue_valid_1         (issue_valid_1),
    .issue_valid_2         (issue_valid_2),
    .issue_entry_1         (issue_entry_1),
    .issue_entry_2         (issue_entry_2),
    .prmiss                (prmiss),
    .prmiss_rob_num        (prmiss_rob_num),
    .prmiss_rob_sorting_bit(prmiss_rob_sorting_bit),
    .iq_entry_num_1        (iq_entry_num_1),
    .iq_entry_num_2        (iq_entry_num_2),
    .allocatable           (allocatable)
  );

  task automatic idle();
    reset = 1'b0; invalid1 = 1'b1; invalid2 = 1'b1; stall_DP = 1'b0;
    rob_num_1 = '0; rob_num_2 = '0; rob_sorting_bit_1 = 1'b0; rob_sorting_bit_2 = 1'b0;
    issue_valid_1 = 1'b0; issue_valid_2 = 1'b0; issue_entry_1 = '0; issue_entry_2 = '0;
    prmiss = 1'b0; prmiss_rob_num = '0; prmiss_rob_sorting_bit = 1'b0;
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    idle();
  endtask

  task automatic dispatch(input logic v1, input logic s1, input logic [5:0] r1,
                          input logic v2, input logic s2, input logic [5:0] r2);
    invalid1 = !v1; rob_sorting_bit_1 = s1; rob_num_1 = r1;
    invalid2 = !v2; rob_sorting_bit_2 = s2; rob_num_2 = r2;
    tick();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (iq_entry_num_1 !== 4'd0) $display("FAIL reset_num1: got %0d exp 0", iq_entry_num_1);
    else n_pass++;
    n_total++;
    if (iq_entry_num_2 !== 4'd1) $display("FAIL reset_num2: got %0d exp 1", iq_entry_num_2);
    else n_pass++;
    n_total++;
    if (allocatable !== 1'b1) $display("FAIL reset_alloc: got %0b exp 1", allocatable);
    else n_pass++;
  endtask

  task automatic test_dispatch();
    do_reset();
    dispatch(1'b1, 1'b0, 6'd1, 1'b1, 1'b0, 6'd2);
    n_total++;
    if (iq_entry_num_1 !== 4'd2) $display("FAIL disp_num1: got %0d exp 2", iq_entry_num_1);
    else n_pass++;
    n_total++;
    if (iq_entry_num_2 !== 4'd3) $display("FAIL disp_num2: got %0d exp 3", iq_entry_num_2);
    else n_pass++;
    // Release of entry 0 alongside allocation of 2 and 3.
    issue_valid_1 = 1'b1; issue_entry_1 = 4'd0;
    dispatch(1'b1, 1'b0, 6'd3, 1'b1, 1'b0, 6'd4);
    n_total++;
    if (iq_entry_num_1 !== 4'd0) $display("FAIL relalloc_num1: got %0d exp 0", iq_entry_num_1);
    else n_pass++;
    n_total++;
    if (iq_entry_num_2 !== 4'd4) $display("FAIL relalloc_num2: got %0d exp 4", iq_entry_num_2);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      dispatch(1'b1, 1'b0, 6'(2 * k), 1'b1, 1'b0, 6'(2 * k + 1));
      n_total++;
      if (iq_entry_num_1 !== 4'(2 * k + 2))
        $display("FAIL b2b_num1[%0d]: got %0d exp %0d", k, iq_entry_num_1, 2 * k + 2);
      else n_pass++;
      n_total++;
      if (iq_entry_num_2 !== 4'(2 * k + 3))
        $display("FAIL b2b_num2[%0d]: got %0d exp %0d", k, iq_entry_num_2, 2 * k + 3);
      else n_pass++;
    end
    n_total++;
    if (allocatable !== 1'b1) $display("FAIL b2b_alloc2free: got %0b exp 1", allocatable);
    else n_pass++;
    // Entry 14 taken, only 15 left free.
    dispatch(1'b1, 1'b0, 6'd20, 1'b0, 1'b0, 6'd0);
    n_total++;
    if (allocatable !== 1'b0) $display("FAIL full_alloc: got %0b exp 0", allocatable);
    else n_pass++;
    // Protocol violation: dispatch without stall while not allocatable is dropped.
    dispatch(1'b1, 1'b0, 6'd21, 1'b1, 1'b0, 6'd22);
    n_total++;
    if (allocatable !== 1'b0) $display("FAIL viol_alloc: got %0b exp 0", allocatable);
    else n_pass++;
    stall_DP = 1'b1; issue_valid_1 = 1'b1; issue_entry_1 = 4'd5;
    dispatch(1'b1, 1'b0, 6'd23, 1'b1, 1'b0, 6'd24);
    n_total++;
    if (allocatable !== 1'b1) $display("FAIL reissue_alloc: got %0b exp 1", allocatable);
    else n_pass++;
    n_total++;
    if (iq_entry_num_1 !== 4'd5) $display("FAIL reissue_num1: got %0d exp 5", iq_entry_num_1);
    else n_pass++;
    n_total++;
    if (iq_entry_num_2 !== 4'd15) $display("FAIL reissue_num2: got %0d exp 15", iq_entry_num_2);
    else n_pass++;
  endtask

  task automatic test_invalid1();
    do_reset();
    dispatch(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd9);
    n_total++;
    if (iq_entry_num_1 !== 4'd0) $display("FAIL inv1_num1: got %0d exp 0", iq_entry_num_1);
    else n_pass++;
    n_total++;
    if (iq_entry_num_2 !== 4'd2) $display("FAIL inv1_num2: got %0d exp 2", iq_entry_num_2);
    else n_pass++;
  endtask

  task automatic test_prmiss();
    do_reset();
    // Entries 0:(0,3) 1:(0,7) 2:(1,1) 3:(0,5)
    dispatch(1'b1, 1'b0, 6'd3, 1'b1, 1'b0, 6'd7);
    dispatch(1'b1, 1'b1, 6'd1, 1'b1, 1'b0, 6'd5);
    n_total++;
    if (iq_entry_num_1 !== 4'd4) $display("FAIL pre_pm_num1: got %0d exp 4", iq_entry_num_1);
    else n_pass++;
    prmiss = 1'b1; prmiss_rob_num = 6'd5; prmiss_rob_sorting_bit = 1'b0;
    dispatch(1'b1, 1'b0, 6'd8, 1'b1, 1'b0, 6'd9);
    n_total++;
    if (iq_entry_num_1 !== 4'd1) $display("FAIL pm_num1: got %0d exp 1", iq_entry_num_1);
    else n_pass++;
    n_total++;
    if (iq_entry_num_2 !== 4'd2) $display("FAIL pm_num2: got %0d exp 2", iq_entry_num_2);
    else n_pass++;
    // Refill 1,2: entries 3 (equal tag) and 4,5 (ignored dispatch) reveal state.
    dispatch(1'b1, 1'b0, 6'd6, 1'b1, 1'b0, 6'd8);
    n_total++;
    if (iq_entry_num_1 !== 4'd4) $display("FAIL post_pm_num1: got %0d exp 4", iq_entry_num_1);
    else n_pass++;
    n_total++;
    if (iq_entry_num_2 !== 4'd5) $display("FAIL post_pm_num2: got %0d exp 5", iq_entry_num_2);
    else n_pass++;
  endtask

  task automatic test_dual_issue();
    do_reset();
    for (int k = 0; k < 7; k++) dispatch(1'b1, 1'b0, 6'(k), 1'b1, 1'b0, 6'(k));
    dispatch(1'b1, 1'b0, 6'd30, 1'b0, 1'b0, 6'd0);
    // Only entry 15 free; both ports release entry 4.
    stall_DP = 1'b1;
    issue_valid_1 = 1'b1; issue_entry_1 = 4'd4;
    issue_valid_2 = 1'b1; issue_entry_2 = 4'd4;
    tick(); idle();
    n_total++;
    if (iq_entry_num_1 !== 4'd4 || iq_entry_num_2 !== 4'd15)
      $display("FAIL dual_nums: got %0d,%0d exp 4,15", iq_entry_num_1, iq_entry_num_2);
    else n_pass++;
    dispatch(1'b1, 1'b0, 6'd31, 1'b1, 1'b0, 6'd32);
    n_total++;
    if (allocatable !== 1'b0) $display("FAIL dual_refill_alloc: got %0b exp 0", allocatable);
    else n_pass++;
    // One release leaves a single free entry: still not allocatable.
    stall_DP = 1'b1; issue_valid_1 = 1'b1; issue_entry_1 = 4'd0;
    tick(); idle();
    n_total++;
    if (allocatable !== 1'b0) $display("FAIL dual_cnt1_alloc: got %0b exp 0", allocatable);
    else n_pass++;
    stall_DP = 1'b1; issue_valid_2 = 1'b1; issue_entry_2 = 4'd1;
    tick(); idle();
    n_total++;
    if (allocatable !== 1'b1) $display("FAIL dual_cnt2_alloc: got %0b exp 1", allocatable);
    else n_pass++;
    // Releasing already-free entry 0 must not bump the count.
    stall_DP = 1'b1; issue_valid_1 = 1'b1; issue_entry_1 = 4'd0;
    tick(); idle();
    n_total++;
    if (iq_entry_num_1 !== 4'd0 || iq_entry_num_2 !== 4'd1)
      $display("FAIL stale_nums: got %0d,%0d exp 0,1", iq_entry_num_1, iq_entry_num_2);
    else n_pass++;
    dispatch(1'b1, 1'b0, 6'd33, 1'b1, 1'b0, 6'd34);
    n_total++;
    if (allocatable !== 1'b0) $display("FAIL stale_alloc: got %0b exp 0", allocatable);
    else n_pass++;
  endtask

  task automatic test_reset_in_prmiss();
    dispatch(1'b1, 1'b0, 6'd1, 1'b1, 1'b0, 6'd2);
    reset = 1'b1; prmiss = 1'b1; prmiss_rob_num = 6'd0; prmiss_rob_sorting_bit = 1'b1;
    invalid1 = 1'b0; invalid2 = 1'b0;
    tick(); idle();
    n_total++;
    if (iq_entry_num_1 !== 4'd0 || iq_entry_num_2 !== 4'd1)
      $display("FAIL rstpm_nums: got %0d,%0d exp 0,1", iq_entry_num_1, iq_entry_num_2);
    else n_pass++;
    n_total++;
    if (allocatable !== 1'b1) $display("FAIL rstpm_alloc: got %0b exp 1", allocatable);
    else n_pass++;
    for (int k = 0; k < 7; k++) dispatch(1'b1, 1'b0, 6'(k), 1'b1, 1'b0, 6'(k));
    n_total++;
    if (iq_entry_num_1 !== 4'd14 || iq_entry_num_2 !== 4'd15 || allocatable !== 1'b1)
      $display("FAIL rstpm_allfree: got %0d,%0d,%0b exp 14,15,1",
               iq_entry_num_1, iq_entry_num_2, allocatable);
    else n_pass++;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_dispatch();
    test_back_to_back();
    test_invalid1();
    test_prmiss();
    test_dual_issue();
    test_reset_in_prmiss();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/iq_entry_allocator.md
Name: iq_entry_allocator

Overview:
- Dispatch-side partner of the issue queue. Picks up to 2 free IQ entry indices per cycle and drives iq_entry_num_1/2 and the stall condition into the IQ allocation port.
- Reclaims entries when the select logic issues them.
- On a branch mispredict, bulk-frees every entry holding an instruction younger than the mispredicted one, using a per-entry ROB tag.

Parameters:
- ENT_NUM, 16 (`IQ_ENT_NUM): number of IQ entries.
- ENT_SEL, 4 (`IQ_ENT_SEL): entry index width, equal to log2(ENT_NUM).
- ROB_SEL, 6 (`ROB_SEL): ROB index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- invalid1  in  1  dispatch slot 1 carries no instruction
- invalid2  in  1  dispatch slot 2 carries no instruction
- stall_DP  in  1  dispatch stalled; no allocation this cycle
- rob_num_1  in  ROB_SEL  ROB tag of slot 1
- rob_num_2  in  ROB_SEL  ROB tag of slot 2
- rob_sorting_bit_1  in  1  ROB wrap bit of slot 1
- rob_sorting_bit_2  in  1  ROB wrap bit of slot 2
- issue_valid_1  in  1  entry issued on select port 1
- issue_valid_2  in  1  entry issued on select port 2
- issue_entry_1  in  ENT_SEL  issued entry index, port 1
- issue_entry_2  in  ENT_SEL  issued entry index, port 2
- prmiss  in  1  branch mispredict recovery
- prmiss_rob_num  in  ROB_SEL  ROB tag of the mispredicted branch
- prmiss_rob_sorting_bit  in  1  wrap bit of the mispredicted branch
- iq_entry_num_1  out  ENT_SEL  lowest free entry
- iq_entry_num_2  out  ENT_SEL  second-lowest free entry
- allocatable  out  1  at least 2 entries free; dispatch stalls when low

Behaviour:
- State:
  - free[ENT_NUM] bit vector, 1 = free.
  - Per-entry tag[i] = {sorting_bit, rob_num}.
  - free_cnt counter, ENT_SEL+1 bits.
- Reset (synchronous):
  - free = all ones; free_cnt = ENT_NUM; tags cleared.
  - Outputs are combinational from state, so after reset: iq_entry_num_1 = 0, iq_entry_num_2 = 1, allocatable = 1.
- Selection (combinational, 0-cycle):
  - iq_entry_num_1 = index of the lowest set bit of free.
  - iq_entry_num_2 = index of the next set bit above it.
  - If fewer than 2 entries are free, both outputs are don't-care and allocatable = 0.
- allocatable = (free_cnt >= 2), registered-state derived.
- Allocation commit (posedge, prmiss = 0, stall_DP = 0, allocatable = 1):
  - If ~invalid1: clear free[iq_entry_num_1] and store tag from slot 1.
  - Likewise for slot 2 with iq_entry_num_2, independent of invalid1.
  - Slot 2 always uses the second-lowest entry, matching the IQ write index.
- Upstream must hold stall_DP = 1 whenever allocatable = 0. If it does not, the allocator ignores the allocation, which is a protocol error.
- Release (posedge, any cycle including prmiss):
  - issue_valid_k sets free[issue_entry_k].
  - Releasing an already-free entry changes nothing; free_cnt is computed only from actual 0→1 transitions.
  - Both ports naming the same entry count as a single release.
- Mispredict (posedge, prmiss = 1):
  - Allocation is suppressed, matching IQ priority.
  - Every allocated entry i whose tag is younger than prmiss is set free.
  - Younger means: (sb == psb && rob > prob) || (sb != psb && rob < prob).
  - An entry with a tag equal to prmiss is kept.
  - Issue releases in the same cycle are OR-ed in.
- Simultaneous events:
  - An entry being allocated cannot be released in the same cycle, since it was free beforehand.
  - A release and an allocation of different entries both take effect.
  - free_cnt next = popcount(free_next). Optionally maintain it incrementally, but it must always equal popcount(free).
- Reset dominates prmiss, which dominates allocation.

Optional Feature:
- IQ_ALLOC_CHECK_EN.
- Defined: add simulation-only checks that $error on:
  - allocation attempted while allocatable = 0;
  - issue of an already-free entry;
  - free_cnt != popcount(free).
  - Also adds output free_count [ENT_SEL:0] for the perf counters.
- Undefined: no checks and no free_count port. Functional behaviour is identical.

Decomposition:
- ENT_NUM, ENT_SEL and ROB_SEL come from constants.vh (`IQ_ENT_NUM, `IQ_ENT_SEL, `ROB_SEL). No new typedefs.
- Age-compare function (isyounger) goes in a shared include, reused later by the ROB and LSQ flush logic.
- One sub-module: first_two_set, a parameterised priority encoder returning the lowest and second-lowest set-bit indices plus valid bits.

Test Plan:
- Reset then dispatch 2 valid, no stall → nums 0,1; next cycle nums 2,3; free_cnt 14.
- Fill to 15 allocated (free_cnt = 1) → allocatable = 0. With stall_DP held, issue entry 5 → next cycle free_cnt 2, allocatable = 1, nums 5,15.
- invalid1 = 1, invalid2 = 0 with nums 0,1 → only entry 1 allocated; next cycle nums 0,2.
- Allocate tags (sb0, rob 3), (sb0, rob 7), (sb1, rob 1); prmiss with sb0 rob 5 → rob 7 and the sb1 entry freed, rob 3 kept. Same-cycle dispatch ignored.
- issue_valid_1 and issue_valid_2 both name entry 4, which is allocated → free_cnt increments by 1 only. Issuing an already-free entry → no change, and an error fires if IQ_ALLOC_CHECK_EN is defined.
- Assert reset in the middle of a prmiss cycle → all entries free, nums 0,1, allocatable = 1 on the next cycle.
